// File: rtl/codec_i2c_pkg.sv
// Shared types and constants for the codec control-port responder.
// Register indices follow the codec's programming map.
package codec_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_BYTE1,
    ST_ACK1,
    ST_BYTE2,
    ST_ACK2,
    ST_WAIT_STOP,
    ST_IGNORE
  } state_t;

  localparam logic [6:0] DEV_ADDR_DEF  = 7'h1A;
  localparam logic [6:0] RESET_REG_IDX = 7'd15;

  localparam logic [6:0] REG_LLINE_IN  = 7'd0;
  localparam logic [6:0] REG_RLINE_IN  = 7'd1;
  localparam logic [6:0] REG_LHP_OUT   = 7'd2;
  localparam logic [6:0] REG_RHP_OUT   = 7'd3;
  localparam logic [6:0] REG_ANA_PATH  = 7'd4;
  localparam logic [6:0] REG_DIG_PATH  = 7'd5;
  localparam logic [6:0] REG_PWR_DOWN  = 7'd6;
  localparam logic [6:0] REG_DIG_IF    = 7'd7;
  localparam logic [6:0] REG_SAMPLING  = 7'd8;
  localparam logic [6:0] REG_ACTIVE    = 7'd9;
  localparam logic [6:0] REG_RESET     = 7'd15;
  localparam logic [6:0] REG_AUX       = 7'd18;

  // Address byte is a write to 'dev' when the R/W bit is 0.
  function automatic logic is_write_to(input logic [7:0] addr_byte, input logic [6:0] dev);
    return addr_byte == {dev, 1'b0};
  endfunction

endpackage

// File: rtl/codec_i2c_responder_if.sv
// Register-side view of the responder: shadow read port plus commit/status outputs.
interface codec_i2c_responder_if #(
  parameter int AW = 5
);
  logic [AW-1:0] RD_ADDR;
  logic [8:0]    RD_DATA;
  logic [6:0]    REG_ADDR;
  logic [8:0]    REG_DATA;
  logic          WR_STROBE;
  logic          BUSY;
  logic          ERR;

  modport master (
    output RD_ADDR,
    input  RD_DATA, REG_ADDR, REG_DATA, WR_STROBE, BUSY, ERR
  );

  modport slave (
    input  RD_ADDR,
    output RD_DATA, REG_ADDR, REG_DATA, WR_STROBE, BUSY, ERR
  );
endinterface

// File: rtl/codec_i2c_responder_line_sync.sv
// SCLK/SDAT synchronizers with one edge-detect stage; emits SCLK edge and START/STOP pulses.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_pin,
  input  logic sda_pin,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl;

  // Reset to the idle-bus level so releasing reset never looks like a bus edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pin};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pin};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl      = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign start    = scl & scl_q & ~sda & sda_q;
  assign stop     = scl & scl_q & sda & ~sda_q;

endmodule

// File: rtl/codec_i2c_responder.sv
// I2C write-only target for the codec control port: ACKs 3-byte writes, commits
// 7-bit register / 9-bit data words and keeps a readable shadow register file.
//
// state        | meaning
// IDLE         | bus free, waiting for START
// ADDR         | shifting in device address + R/W
// ACK_A        | driving ACK for the address byte
// BYTE1        | shifting in {reg[6:0], data[8]}
// ACK1         | driving ACK for byte 1
// BYTE2        | shifting in data[7:0]
// ACK2         | driving ACK for byte 2, word already committed
// WAIT_STOP    | word done; further bytes NACKed, first one flags ERR
// IGNORE       | not addressed, silent until STOP/START
module codec_i2c_responder
  import codec_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEF,
  parameter int         NUM_REGS    = 32,
  parameter logic [6:0] RESET_REG   = RESET_REG_IDX,
  parameter int         SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_L,
  input  logic SCLK,
  inout  wire  SDAT,
  codec_i2c_responder_if.slave bus
);

  localparam int AW = $clog2(NUM_REGS);

  logic       sda;
  logic       scl_rise;
  logic       scl_fall;
  logic       start;
  logic       stop;

  state_t     state;
  logic [2:0] bit_cnt;
  logic       byte_full;
  logic [7:0] shift;
  logic [7:0] byte1;
  logic       sdat_oe;
  logic       err_done;
  logic       busy;
  logic       err;
  logic       wr_strobe;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic [8:0] shadow [NUM_REGS];

  logic [6:0] cmt_reg;
  logic [8:0] cmt_data;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (CLK),
    .rst_n    (RST_L),
    .scl_pin  (SCLK),
    .sda_pin  (SDAT),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign cmt_reg  = byte1[7:1];
  assign cmt_data = {byte1[0], shift};

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      byte_full <= 1'b0;
      shift     <= '0;
      byte1     <= '0;
      sdat_oe   <= 1'b0;
      err_done  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      wr_strobe <= 1'b0;
      reg_addr  <= '0;
      reg_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      err       <= 1'b0;
      if (start) begin
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        byte_full <= 1'b0;
        sdat_oe   <= 1'b0;
        err_done  <= 1'b0;
        busy      <= 1'b1;
      end else if (stop) begin
        if (state inside {ST_ACK_A, ST_BYTE1, ST_ACK1, ST_BYTE2}) err <= 1'b1;
        state   <= ST_IDLE;
        sdat_oe <= 1'b0;
        busy    <= 1'b0;
      end else begin
        // Bits are counted on rising edges; the byte is acted on at the following fall.
        if (scl_rise && (state inside {ST_ADDR, ST_BYTE1, ST_BYTE2, ST_WAIT_STOP})) begin
          shift   <= {shift[6:0], sda};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_full <= 1'b1;
        end
        if (scl_fall) begin
          case (state)
            ST_ADDR: if (byte_full) begin
              byte_full <= 1'b0;
              if (is_write_to(shift, DEV_ADDR)) begin
                state   <= ST_ACK_A;
                sdat_oe <= 1'b1;
              end else begin
                state <= ST_IGNORE;
              end
            end
            ST_ACK_A: begin
              sdat_oe <= 1'b0;
              state   <= ST_BYTE1;
            end
            ST_BYTE1: if (byte_full) begin
              byte_full <= 1'b0;
              byte1     <= shift;
              sdat_oe   <= 1'b1;
              state     <= ST_ACK1;
            end
            ST_ACK1: begin
              sdat_oe <= 1'b0;
              state   <= ST_BYTE2;
            end
            ST_BYTE2: if (byte_full) begin
              byte_full <= 1'b0;
              sdat_oe   <= 1'b1;
              state     <= ST_ACK2;
              reg_addr  <= cmt_reg;
              reg_data  <= cmt_data;
              wr_strobe <= 1'b1;
              if (cmt_reg == RESET_REG) begin
                for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
              end else if (32'(cmt_reg) < NUM_REGS) begin
                shadow[cmt_reg[AW-1:0]] <= cmt_data;
              end
            end
            ST_ACK2: begin
              sdat_oe <= 1'b0;
              state   <= ST_WAIT_STOP;
            end
            ST_WAIT_STOP: if (byte_full) begin
              byte_full <= 1'b0;
              if (!err_done) begin
                err      <= 1'b1;
                err_done <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign SDAT = sdat_oe ? 1'b0 : 1'bz;

  assign bus.RD_DATA   = (32'(bus.RD_ADDR) < NUM_REGS) ? shadow[bus.RD_ADDR] : '0;
  assign bus.REG_ADDR  = reg_addr;
  assign bus.REG_DATA  = reg_data;
  assign bus.WR_STROBE = wr_strobe;
  assign bus.BUSY      = busy;
  assign bus.ERR       = err;

endmodule

// File: tb/tb_codec_i2c_responder.sv
// Directed plus randomized bench for codec_i2c_responder: bit-banged I2C master
// and a register-map reference model held as a plain array.
module tb_codec_i2c_responder;
  import codec_i2c_pkg::*;

  localparam int P = 8;

  logic clk    = 1'b0;
  logic rst_l  = 1'b0;
  logic scl    = 1'b1;
  logic sda_low = 1'b0;
  wire  sdat;

  pullup (sdat);
  assign sdat = sda_low ? 1'b0 : 1'bz;

  codec_i2c_responder_if #(.AW(5)) bus ();

  codec_i2c_responder dut (
    .CLK   (clk),
    .RST_L (rst_l),
    .SCLK  (scl),
    .SDAT  (sdat),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int errs = 0;
  int drives = 0;
  logic [8:0] model [32];

  always @(negedge clk) begin
    if (bus.WR_STROBE === 1'b1) strobes++;
    if (bus.ERR === 1'b1) errs++;
    if (sdat === 1'b0 && !sda_low) drives++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_cond();
    sda_low = 1'b0; idle(P);
    scl = 1'b1;     idle(P);
    sda_low = 1'b1; idle(P);
    scl = 1'b0;     idle(P);
  endtask

  task automatic stop_cond();
    sda_low = 1'b1; idle(P);
    scl = 1'b1;     idle(P);
    sda_low = 1'b0; idle(P);
  endtask

  task automatic send_bit(input logic b);
    sda_low = !b; idle(P);
    scl = 1'b1;   idle(P);
    scl = 1'b0;   idle(P);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked, output logic released);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_low = 1'b0; idle(P);
    scl = 1'b1;     idle(P / 2);
    acked = (sdat === 1'b0);
    idle(P / 2);
    scl = 1'b0;     idle(P);
    released = (sdat === 1'b1);
  endtask

  task automatic model_write(input logic [6:0] r, input logic [8:0] d);
    if (r == 7'd15) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (r < 7'd32) begin
      model[r[4:0]] = d;
    end
  endtask

  task automatic check_read(input int idx);
    bus.RD_ADDR = idx[4:0];
    #1;
    check($sformatf("rd_data[%0d]", idx), bus.RD_DATA, model[idx]);
  endtask

  task automatic check_shadow();
    for (int i = 0; i < 32; i++) check_read(i);
  endtask

  task automatic do_write(input logic [6:0] r, input logic [8:0] d);
    int s0, e0;
    logic a0, a1, a2, r0, r1, r2;
    s0 = strobes;
    e0 = errs;
    start_cond();
    check("busy_after_start", bus.BUSY, 1);
    send_byte(8'h34, a0, r0);
    send_byte({r, d[8]}, a1, r1);
    send_byte(d[7:0], a2, r2);
    stop_cond();
    model_write(r, d);
    check("wr_acks", {a0, a1, a2}, 3'b111);
    check("wr_released", {r0, r1, r2}, 3'b111);
    check("wr_strobe_count", strobes - s0, 1);
    check("wr_err_count", errs - e0, 0);
    check("reg_addr", bus.REG_ADDR, r);
    check("reg_data", bus.REG_DATA, d);
    check("busy_after_stop", bus.BUSY, 0);
  endtask

  initial begin
    logic a, rl;
    int s0, e0, d0;
    logic [6:0] r;
    logic [8:0] d;

    bus.RD_ADDR = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // reset state
    idle(3);
    check("rst_busy", bus.BUSY, 0);
    check("rst_strobe", bus.WR_STROBE, 0);
    check("rst_err", bus.ERR, 0);
    check("rst_reg_addr", bus.REG_ADDR, 0);
    check("rst_reg_data", bus.REG_DATA, 0);
    check("rst_sdat", sdat, 1);
    rst_l = 1'b1;
    idle(4);
    check_shadow();

    // basic write: reg 6 <= 0x06A
    do_write(7'd6, 9'h06A);
    check_read(6);

    // not addressed: 0x36 then two random bytes
    s0 = strobes; e0 = errs; d0 = drives;
    start_cond();
    send_byte(8'h36, a, rl);
    check("ign_nack", a, 0);
    send_byte(8'($urandom), a, rl);
    send_byte(8'($urandom), a, rl);
    check("ign_busy", bus.BUSY, 1);
    stop_cond();
    check("ign_drive", drives - d0, 0);
    check("ign_strobe", strobes - s0, 0);
    check("ign_err", errs - e0, 0);
    check("ign_busy_stop", bus.BUSY, 0);

    // read request NACKed, then a normal write to reg 18
    s0 = strobes; e0 = errs;
    start_cond();
    send_byte(8'h35, a, rl);
    check("rd_nack", a, 0);
    stop_cond();
    check("rd_strobe", strobes - s0, 0);
    check("rd_err", errs - e0, 0);
    do_write(7'd18, 9'h001);
    check_read(18);

    // abort after first data byte
    do_write(7'd7, 9'($urandom));
    s0 = strobes; e0 = errs;
    start_cond();
    send_byte(8'h34, a, rl);
    send_byte(8'h0E, a, rl);
    stop_cond();
    check("abort_err", errs - e0, 1);
    check("abort_strobe", strobes - s0, 0);
    check_read(7);

    // repeated START discards partial word
    s0 = strobes; e0 = errs;
    start_cond();
    send_byte(8'h34, a, rl);
    send_byte(8'h0E, a, rl);
    start_cond();
    check("rs_busy", bus.BUSY, 1);
    send_byte(8'h34, a, rl);
    send_byte(8'h0E, a, rl);
    send_byte(8'h02, a, rl);
    stop_cond();
    model_write(7'd7, 9'h002);
    check("rs_strobe", strobes - s0, 1);
    check("rs_err", errs - e0, 0);
    check_read(7);

    // extra bytes after a complete word
    s0 = strobes; e0 = errs; d0 = drives;
    r = 7'($urandom_range(0, 31));
    if (r == 7'd15) r = 7'd3;
    d = 9'($urandom);
    start_cond();
    send_byte(8'h34, a, rl);
    send_byte({r, d[8]}, a, rl);
    send_byte(d[7:0], a, rl);
    d0 = drives;
    send_byte(8'($urandom), a, rl);
    check("extra_nack", a, 0);
    send_byte(8'($urandom), a, rl);
    stop_cond();
    model_write(r, d);
    check("extra_drive", drives - d0, 0);
    check("extra_err", errs - e0, 1);
    check("extra_strobe", strobes - s0, 1);
    check_read(r);

    // randomized writes, including out-of-range indices
    for (int n = 0; n < 12; n++) begin
      r = (n == 0) ? 7'd100 : 7'($urandom_range(0, 127));
      if (r == 7'd15) r = 7'd16;
      do_write(r, 9'($urandom));
    end
    check_shadow();

    // fill codec regs then clear with the reset register
    for (int i = 0; i < 10; i++) do_write(7'(i), 9'($urandom_range(1, 511)));
    check_shadow();
    do_write(7'd15, 9'h000);
    check_shadow();

    // reset while the responder is driving ACK
    do_write(7'd5, 9'h155);
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h34 >> i));
    sda_low = 1'b0;
    #1;
    check("ack_drive_before_rst", sdat, 0);
    rst_l = 1'b0;
    #1;
    check("ack_rst_sdat", sdat, 1);
    check("ack_rst_busy", bus.BUSY, 0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    scl = 1'b1;
    idle(P);
    rst_l = 1'b1;
    idle(P);
    check_shadow();

    // reset mid-BYTE1
    do_write(7'd4, 9'h0F0);
    start_cond();
    send_byte(8'h34, a, rl);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_l = 1'b0;
    #1;
    check("b1_rst_sdat", sdat, 1);
    check("b1_rst_busy", bus.BUSY, 0);
    check("b1_rst_reg_addr", bus.REG_ADDR, 0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    sda_low = 1'b0;
    scl = 1'b1;
    idle(P);
    rst_l = 1'b1;
    idle(P);
    do_write(7'($urandom_range(0, 9)), 9'($urandom));
    check_shadow();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
